muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the resolved, forwarded operands SrcAE/SrcBE and holds the pipeline through a stall request until the result is ready. The result is muxed alongside ALUResultE into the E/M register. Shift-add multiply and restoring divide run on shared state, one bit per cycle.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/muldiv_sign_fix.sv | 25 ++
 rtl/muldiv_unit.sv | 113 +++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared M-extension opcode and muldiv FSM state types
package riscv_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: sign correction and word selection of the final muldiv result
module muldiv_sign_fix
    import riscv_pkg::*;
#(
    parameter int word_width = 32
) (
    input  muldiv_op_t                  op_i,
    input  logic [2*word_width-1:0]     acc_i,
    input  logic                        neg_i,
    output logic [word_width-1:0]       result_o
);
    localparam int W = word_width;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    // acc holds {remainder, quotient} for divides and the full product for multiplies
    always_comb begin
        prod     = neg_i ? -acc_i : acc_i;
        quo      = neg_i ? -acc_i[W-1:0] : acc_i[W-1:0];
        rem      = neg_i ? -acc_i[2*W-1:W] : acc_i[2*W-1:W];
        result_o = op_i == MUL ? acc_i[W-1:0] :
                   !op_i[2]    ? prod[2*W-1:W] :
                   op_i[1]     ? rem : quo;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, stalls E until done
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int word_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StartE,
    input  logic [2:0]            MulDivOpE,
    input  logic [word_width-1:0] SrcAE,
    input  logic [word_width-1:0] SrcBE,
    input  logic                  FlushE,
    output logic                  MulDivStallE,
    output logic                  MulDivDoneE,
    output logic [word_width-1:0] MulDivResultE
);
    localparam int W  = word_width;
    localparam int CW = $clog2(W) + 1;
    muldiv_state_t  state_q, state_d;
    muldiv_op_t     op_q, op_d, op_in;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d, mul_nx, div_nx;
    logic [W-1:0]   opr_q, opr_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   res_q, res_d, res_fix;
    logic [W-1:0]   abs_a, abs_b;
    logic           sa, sb, is_div, div_zero, div_ovf;
    logic [W:0]     sum, sh, diff;
    muldiv_sign_fix #(.word_width(W)) u_fix (
        .op_i     (op_q),
        .acc_i    (acc_q),
        .neg_i    (neg_q),
        .result_o (res_fix)
    );
    always_comb begin
        op_in    = muldiv_op_t'(MulDivOpE);
        sa       = (op_in inside {MULH, MULHSU, DIV, REM}) & SrcAE[W-1];
        sb       = (op_in inside {MULH, DIV, REM}) & SrcBE[W-1];
        abs_a    = sa ? -SrcAE : SrcAE;
        abs_b    = sb ? -SrcBE : SrcBE;
        is_div   = MulDivOpE[2];
        div_zero = is_div & (SrcBE == '0);
        div_ovf  = (op_in inside {DIV, REM}) & (SrcAE == {1'b1, {(W-1){1'b0}}}) & (&SrcBE);
        // shift-add: multiplier sits in the low half and shifts out as the product shifts in
        sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        mul_nx   = {sum, acc_q[W-1:1]};
        // restoring divide on {remainder, quotient}
        sh       = acc_q[2*W-1:W-1];
        diff     = sh - {1'b0, opr_q};
        div_nx   = {diff[W] ? sh[W-1:0] : diff[W-1:0], acc_q[W-2:0], ~diff[W]};
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opr_d   = opr_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (FlushE) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (StartE) begin
                op_d  = op_in;
                neg_d = (op_in inside {REM, REMU}) ? sa : sa ^ sb;
                if (div_zero) begin
                    acc_d   = {SrcAE, {W{1'b1}}};
                    neg_d   = 1'b0;
                    state_d = DONE;
                end else if (div_ovf) begin
                    acc_d   = {{W{1'b0}}, SrcAE};
                    neg_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    acc_d   = {{W{1'b0}}, is_div ? abs_a : abs_b};
                    opr_d   = is_div ? abs_b : abs_a;
                    cnt_d   = CW'(W);
                    state_d = CALC;
                end
            end
        end else if (state_q == CALC) begin
            acc_d   = op_q[2] ? div_nx : mul_nx;
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? DONE : CALC;
        end else begin
            res_d   = state_q == DONE ? res_fix : res_q;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opr_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end
    assign MulDivDoneE   = (state_q == DONE) & ~FlushE;
    assign MulDivResultE = MulDivDoneE ? res_fix : res_q;
    assign MulDivStallE  = rst_n & StartE & ~MulDivDoneE & ~FlushE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        StartE;
    logic [2:0]  MulDivOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        FlushE;
    logic        MulDivStallE, MulDivDoneE;
    logic [31:0] MulDivResultE;
    int          errors = 0;
    int          checks = 0;
    muldiv_unit #(.word_width(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StartE        (StartE),
        .MulDivOpE     (MulDivOpE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .FlushE        (FlushE),
        .MulDivStallE  (MulDivStallE),
        .MulDivDoneE   (MulDivDoneE),
        .MulDivResultE (MulDivResultE)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        xa  = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        xb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = xa * xb;
        case (op)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5:    return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6:    return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return b == 0 ? a : a % b;
        endcase
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        logic [31:0] exp;
        int n;
        logic stall_ok;
        exp       = model(op, a, b);
        StartE    = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        n         = 0;
        stall_ok  = 1'b1;
        #1;
        while (!MulDivDoneE && n < 40) begin
            if (!MulDivStallE) stall_ok = 1'b0;
            @(negedge clk);
            if (n == 2) begin
                SrcAE = $urandom;
                SrcBE = $urandom;
            end
            n++;
            #1;
        end
        check($sformatf("stall_busy op%0d", op), 64'(stall_ok), 64'(1));
        check($sformatf("latency op%0d", op), 64'(n), 64'(lat));
        check($sformatf("result op%0d %h,%h", op, a, b), 64'(MulDivResultE), 64'(exp));
        check("stall_on_done", 64'(MulDivStallE), 64'(0));
        @(negedge clk);
        StartE = 1'b0;
        #1;
        check("done_one_cycle", 64'(MulDivDoneE), 64'(0));
        check("result_hold", 64'(MulDivResultE), 64'(exp));
    endtask
    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int pulses;
        rst_n     = 1'b0;
        StartE    = 1'b1;
        MulDivOpE = 3'd0;
        SrcAE     = 32'd7;
        SrcBE     = 32'd3;
        FlushE    = 1'b0;
        #1;
        check("reset_done", 64'(MulDivDoneE), 64'(0));
        check("reset_result", 64'(MulDivResultE), 64'(0));
        check("reset_stall", 64'(MulDivStallE), 64'(0));
        StartE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 33);
        check("mul_7x-3", 64'(MulDivResultE), 64'h0000_0000_FFFF_FFEB);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 33);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 33);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 33);
        do_op(3'd5, 32'd100, 32'd7, 33);
        do_op(3'd7, 32'd100, 32'd7, 33);
        do_op(3'd5, 32'd5, 32'd0, 1);
        do_op(3'd6, 32'd5, 32'd0, 1);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        // flush a divide mid-flight
        StartE    = 1'b1;
        MulDivOpE = 3'd4;
        SrcAE     = 32'd1000;
        SrcBE     = 32'd3;
        for (int i = 0; i < 10; i++) @(negedge clk);
        FlushE = 1'b1;
        #1;
        check("flush_stall", 64'(MulDivStallE), 64'(0));
        check("flush_done", 64'(MulDivDoneE), 64'(0));
        @(negedge clk);
        FlushE = 1'b0;
        StartE = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (MulDivDoneE) pulses++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(pulses), 64'(0));
        do_op(3'd0, 32'd3, 32'd4, 33);
        // async reset in the middle of a multiply
        StartE    = 1'b1;
        MulDivOpE = 3'd0;
        SrcAE     = 32'd123;
        SrcBE     = 32'd456;
        for (int i = 0; i < 15; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_result", 64'(MulDivResultE), 64'(0));
        check("midreset_done", 64'(MulDivDoneE), 64'(0));
        check("midreset_stall", 64'(MulDivStallE), 64'(0));
        StartE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3'd3, 32'd2, 32'd3, 33);
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 6 == 5) ? 32'd0 : (i % 4 == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 7 == 6) a = -($urandom_range(0, 50));
            do_op(op, a, b, (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
